// File: rtl/writeback_pkg.sv
// Shared types and constants for the write-back stage: widths, link register,
// FSM encodings and the MEM/WB latch record.
package writeback_pkg;

    localparam int DATA_W = 16;
    localparam int REG_W  = 3;
    localparam int CNT_W  = 16;

    localparam logic [REG_W-1:0] LINK_REG = 3'h7;

    typedef enum logic {
        WB_RUN    = 1'b0,
        WB_HALTED = 1'b1
    } wb_state_e;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] alu_result;
        logic [DATA_W-1:0] read_data;
        logic [DATA_W-1:0] pc_plus2;
        logic [REG_W-1:0]  write_reg;
        logic              RegWrite;
        logic              MemToReg;
        logic              PcToReg;
        logic              Halt;
        logic              err;
    } memwb_t;

endpackage

// File: rtl/writeback_if.sv
// MEM-stage inputs and register-file write-port outputs of the write-back stage.
// slave = writeback itself, master = the MEM stage / register-file side.
interface writeback_if;
    import writeback_pkg::*;

    logic              mem_valid;
    logic [DATA_W-1:0] mem_alu_result;
    logic [DATA_W-1:0] mem_read_data;
    logic [DATA_W-1:0] mem_pc_plus2;
    logic [REG_W-1:0]  mem_write_reg;
    logic              mem_RegWrite;
    logic              mem_MemToReg;
    logic              mem_PcToReg;
    logic              mem_Halt;
    logic              mem_err;

    logic [DATA_W-1:0] Writeback_data;
    logic [REG_W-1:0]  Writeback_reg;
    logic              RegWrite_cntrl;
    logic              fwd_valid;
    logic              halted;
    logic [CNT_W-1:0]  retired;
    logic              err;

    modport slave (
        input  mem_valid, mem_alu_result, mem_read_data, mem_pc_plus2,
               mem_write_reg, mem_RegWrite, mem_MemToReg, mem_PcToReg,
               mem_Halt, mem_err,
        output Writeback_data, Writeback_reg, RegWrite_cntrl, fwd_valid,
               halted, retired, err
    );

    modport master (
        output mem_valid, mem_alu_result, mem_read_data, mem_pc_plus2,
               mem_write_reg, mem_RegWrite, mem_MemToReg, mem_PcToReg,
               mem_Halt, mem_err,
        input  Writeback_data, Writeback_reg, RegWrite_cntrl, fwd_valid,
               halted, retired, err
    );

endinterface

// File: rtl/writeback_memwb_latch.sv
// MEM/WB pipeline latch: a plain async-reset register bank, captures every edge.
module memwb_latch #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_q <= '0;
        else     r_q <= i_d;
    end

    assign o_q = r_q;

endmodule

// File: rtl/writeback.sv
// Write-back stage: MEM/WB latch, result select, register-file write port,
// halt-commit FSM, sticky error flag and retired-instruction counter.
//
//  state     | meaning
//  ----------+-------------------------------------------------------------
//  WB_RUN    | normal operation: writes, retires and error updates allowed
//  WB_HALTED | HALT committed; latch keeps capturing, everything else frozen
module writeback
    import writeback_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    writeback_if.slave bus
);

    memwb_t            w_mem;
    logic [$bits(memwb_t)-1:0] w_wb_bits;
    memwb_t            w_wb;
    wb_state_e         r_state;
    wb_state_e         w_state_nxt;
    logic [CNT_W-1:0]  r_retired;
    logic              r_err;
    logic              w_run;
    logic              w_commit;
    logic              w_sel_conflict;

    assign w_mem.valid      = bus.mem_valid;
    assign w_mem.alu_result = bus.mem_alu_result;
    assign w_mem.read_data  = bus.mem_read_data;
    assign w_mem.pc_plus2   = bus.mem_pc_plus2;
    assign w_mem.write_reg  = bus.mem_write_reg;
    assign w_mem.RegWrite   = bus.mem_RegWrite;
    assign w_mem.MemToReg   = bus.mem_MemToReg;
    assign w_mem.PcToReg    = bus.mem_PcToReg;
    assign w_mem.Halt       = bus.mem_Halt;
    assign w_mem.err        = bus.mem_err;

    memwb_latch #(.W($bits(memwb_t))) u_latch (
        .clk (clk),
        .rst (rst),
        .i_d (w_mem),
        .o_q (w_wb_bits)
    );

    assign w_wb = memwb_t'(w_wb_bits);

    assign w_run          = (r_state == WB_RUN);
    assign w_commit       = w_wb.valid & w_run;
    assign w_sel_conflict = w_wb.MemToReg & w_wb.PcToReg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= WB_RUN;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            WB_RUN:    if (w_wb.valid & w_wb.Halt) w_state_nxt = WB_HALTED;
            WB_HALTED: w_state_nxt = WB_HALTED;
            default:   w_state_nxt = WB_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_retired <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_commit)
                r_retired <= r_retired + CNT_W'(1);
            if (w_commit & (w_wb.err | w_sel_conflict))
                r_err <= 1'b1;
        end
    end

    // PcToReg has priority, so a MemToReg/PcToReg conflict still writes the link value.
    assign bus.Writeback_data = w_wb.PcToReg ? w_wb.pc_plus2  :
                                w_wb.MemToReg ? w_wb.read_data : w_wb.alu_result;
    assign bus.Writeback_reg  = w_wb.PcToReg ? LINK_REG : w_wb.write_reg;

    // HALT never writes, even when it carries RegWrite.
    assign bus.RegWrite_cntrl = w_commit & w_wb.RegWrite & ~w_wb.Halt;
    assign bus.fwd_valid      = bus.RegWrite_cntrl;
    assign bus.halted         = (r_state == WB_HALTED);
    assign bus.retired        = r_retired;
    assign bus.err            = r_err;

endmodule
